// File: rtl/lcd_timing_receiver.sv
// ---------------------------------------------------------------------------
// LcdTimingReceiver (module lcd_timing_receiver)
//
// Receiving end of an LCD timing interface. It recovers per-pixel x/y
// coordinates from an hs_n / vs_n / data_enable stream qualified by a pixel
// tick. It also measures the line and frame geometry, and it declares lock
// once two consecutive complete frames agree with each other and with the
// expected visible size.
//
// Ports:
//   clock        system clock
//   reset        synchronous reset, active high (overrides tick)
//   tick         pixel strobe; inputs are sampled only on tick cycles
//   hs_n, vs_n   horizontal / vertical sync, active low
//   data_enable  active-pixel qualifier
//   x, y         recovered pixel column / row (saturate at 1023)
//   pixel_valid  x/y refer to a visible pixel
//   frame_start  one-clock pulse at the first visible pixel of a frame
//   h_total      ticks per line (hs_n fall to hs_n fall)
//   v_total      lines per frame (hs_n falls between vs_n falls)
//   h_active     data_enable-high ticks of the last complete line
//   v_active     lines containing data_enable in the last complete frame
//   locked       geometry stable and equal to H_ACT x V_ACT
//   error        one-clock pulse on loss of lock
// ---------------------------------------------------------------------------
module lcd_timing_receiver #(
    parameter int H_ACT = 800,
    parameter int V_ACT = 480,
    parameter int MAX_H = 2047
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        tick,
    input  logic        hs_n,
    input  logic        vs_n,
    input  logic        data_enable,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        pixel_valid,
    output logic        frame_start,
    output logic [10:0] h_total,
    output logic [10:0] v_total,
    output logic [10:0] h_active,
    output logic [10:0] v_active,
    output logic        locked,
    output logic        error
);

    typedef enum logic [1:0] {
        SEARCH,
        MEASURE,
        LOCKED
    } state_t;

    localparam logic [10:0] MAX_CNT = 11'(MAX_H);
    localparam logic [10:0] H_ACT_C = 11'(H_ACT);
    localparam logic [10:0] V_ACT_C = 11'(V_ACT);
    localparam logic [9:0]  MAX_POS = 10'd1023;

    state_t      state_q;

    logic        hsPrev_q;
    logic        vsPrev_q;
    logic        dePrev_q;

    logic [10:0] hCnt_q, hCnt_d;
    logic [10:0] deCnt_q, deCnt_d;
    logic [10:0] lineCnt_q, lineCnt_d;
    logic [10:0] deLineCnt_q, deLineCnt_d;
    logic [10:0] lineNext;

    logic [10:0] hTotal_q, hTotal_d;
    logic [10:0] vTotal_q, vTotal_d;
    logic [10:0] hActive_q, hActive_d;
    logic [10:0] vActive_q, vActive_d;

    logic [10:0] refHTotal_q;
    logic [10:0] refVTotal_q;
    logic [10:0] refHActive_q;
    logic [10:0] refVActive_q;

    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic        pixelValid_q, pixelValid_d;
    logic        frameStart_q, frameStart_d;
    logic        frameArmed_q, frameArmed_d;
    logic        armedNow;
    logic        locked_q;
    logic        error_q;

    logic        hsFall;
    logic        vsFall;
    logic        deRise;
    logic        deFall;
    logic        hCntSaturating;
    logic        frameMatch;
    logic        lossOfLock;

    function automatic logic [10:0] satInc11(input logic [10:0] v);
        return (v >= MAX_CNT) ? MAX_CNT : v + 11'd1;
    endfunction

    function automatic logic [9:0] satInc10(input logic [9:0] v);
        return (v == MAX_POS) ? MAX_POS : v + 10'd1;
    endfunction

    // Edge detection against the sample taken on the previous tick. These
    // are only acted upon on tick cycles.
    assign hsFall = hsPrev_q & ~hs_n;
    assign vsFall = vsPrev_q & ~vs_n;
    assign deRise = ~dePrev_q & data_enable;
    assign deFall = dePrev_q & ~data_enable;

    // Geometry counters. The line counter includes an hs_n fall that lands
    // on the same tick as the vs_n fall, so that line closes the old frame.
    // A data_enable rise on the vs_n fall tick belongs to the new frame.
    always_comb begin
        hCnt_d      = hsFall ? 11'd0 : satInc11(hCnt_q);
        hTotal_d    = hsFall ? satInc11(hCnt_q) : hTotal_q;

        deCnt_d     = deCnt_q;
        if (deRise) begin
            deCnt_d = 11'd1;
        end else if (data_enable) begin
            deCnt_d = satInc11(deCnt_q);
        end
        hActive_d   = deFall ? deCnt_q : hActive_q;

        lineNext    = hsFall ? satInc11(lineCnt_q) : lineCnt_q;
        lineCnt_d   = vsFall ? 11'd0 : lineNext;
        vTotal_d    = vsFall ? lineNext : vTotal_q;

        vActive_d   = vsFall ? deLineCnt_q : vActive_q;
        deLineCnt_d = deLineCnt_q;
        if (vsFall) begin
            deLineCnt_d = deRise ? 11'd1 : 11'd0;
        end else if (deRise) begin
            deLineCnt_d = satInc11(deLineCnt_q);
        end
    end

    // Pixel coordinate tracking. A vs_n fall arms the next data_enable rise
    // to become row 0 of a new frame.
    always_comb begin
        armedNow     = frameArmed_q | vsFall;
        x_d          = x_q;
        y_d          = y_q;
        pixelValid_d = pixelValid_q;
        frameStart_d = 1'b0;
        frameArmed_d = armedNow;
        if (deRise) begin
            x_d          = 10'd0;
            pixelValid_d = 1'b1;
            frameArmed_d = 1'b0;
            if (armedNow) begin
                y_d          = 10'd0;
                frameStart_d = 1'b1;
            end else begin
                y_d = satInc10(y_q);
            end
        end else if (data_enable) begin
            x_d          = satInc10(x_q);
            pixelValid_d = 1'b1;
        end else begin
            x_d          = 10'd0;
            pixelValid_d = 1'b0;
        end
    end

    // Lock qualification. The line counter reaching saturation without an
    // hs_n fall is the single tick on which a stuck input is reported.
    always_comb begin
        hCntSaturating = ~hsFall && (hCnt_q == MAX_CNT - 11'd1);
        frameMatch     = (hTotal_d == refHTotal_q) && (vTotal_d == refVTotal_q) &&
                         (hActive_d == refHActive_q) && (vActive_d == refVActive_q) &&
                         (hActive_d == H_ACT_C) && (vActive_d == V_ACT_C);
        lossOfLock     = (hsFall && (hTotal_d != refHTotal_q)) ||
                         (deFall && (deCnt_q != H_ACT_C)) ||
                         (vsFall && ((vTotal_d != refVTotal_q) ||
                                     (vActive_d != refVActive_q))) ||
                         hCntSaturating;
    end

    // All state advances only on tick cycles; the two pulses are cleared on
    // every clock so they last exactly one clock. The FSM only acts on
    // frame boundaries until it is locked, after which any disagreeing
    // line, active width or frame drops it back to MEASURE with the new
    // values as the reference.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= SEARCH;
            hsPrev_q     <= 1'b1;
            vsPrev_q     <= 1'b1;
            dePrev_q     <= 1'b0;
            hCnt_q       <= '0;
            deCnt_q      <= '0;
            lineCnt_q    <= '0;
            deLineCnt_q  <= '0;
            hTotal_q     <= '0;
            vTotal_q     <= '0;
            hActive_q    <= '0;
            vActive_q    <= '0;
            refHTotal_q  <= '0;
            refVTotal_q  <= '0;
            refHActive_q <= '0;
            refVActive_q <= '0;
            x_q          <= '0;
            y_q          <= '0;
            pixelValid_q <= 1'b0;
            frameStart_q <= 1'b0;
            frameArmed_q <= 1'b0;
            locked_q     <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            frameStart_q <= 1'b0;
            error_q      <= 1'b0;
            if (tick) begin
                hsPrev_q     <= hs_n;
                vsPrev_q     <= vs_n;
                dePrev_q     <= data_enable;
                hCnt_q       <= hCnt_d;
                deCnt_q      <= deCnt_d;
                lineCnt_q    <= lineCnt_d;
                deLineCnt_q  <= deLineCnt_d;
                hTotal_q     <= hTotal_d;
                vTotal_q     <= vTotal_d;
                hActive_q    <= hActive_d;
                vActive_q    <= vActive_d;
                x_q          <= x_d;
                y_q          <= y_d;
                pixelValid_q <= pixelValid_d;
                frameStart_q <= frameStart_d;
                frameArmed_q <= frameArmed_d;
                case (state_q)
                    SEARCH: begin
                        if (vsFall) begin
                            state_q <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        if (vsFall) begin
                            refHTotal_q  <= hTotal_d;
                            refVTotal_q  <= vTotal_d;
                            refHActive_q <= hActive_d;
                            refVActive_q <= vActive_d;
                            if (frameMatch) begin
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                            end
                        end
                    end
                    LOCKED: begin
                        if (lossOfLock) begin
                            error_q      <= 1'b1;
                            locked_q     <= 1'b0;
                            state_q      <= MEASURE;
                            refHTotal_q  <= hTotal_d;
                            refVTotal_q  <= vTotal_d;
                            refHActive_q <= hActive_d;
                            refVActive_q <= vActive_d;
                        end
                    end
                    default: begin
                        state_q <= SEARCH;
                    end
                endcase
            end
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign pixel_valid = pixelValid_q;
    assign frame_start = frameStart_q;
    assign h_total     = hTotal_q;
    assign v_total     = vTotal_q;
    assign h_active    = hActive_q;
    assign v_active    = vActive_q;
    assign locked      = locked_q;
    assign error       = error_q;

endmodule

// File: tb/tb_lcd_timing_receiver.sv
// ---------------------------------------------------------------------------
// Testbench for lcd_timing_receiver. A reduced 20x8 geometry keeps frames
// short (32 ticks per line, 13 lines per frame). The reference model keeps
// the tick indices of every sync and data_enable edge and derives the
// expected outputs from distances and counts over that history.
// ---------------------------------------------------------------------------
module tb_lcd_timing_receiver;

    localparam int HA    = 20;
    localparam int VA    = 8;
    localparam int MAXH  = 2047;
    localparam int HSYNC = 4;
    localparam int HBP   = 6;
    localparam int HTOT  = 32;
    localparam int VSYNC = 2;
    localparam int VBP   = 2;
    localparam int VTOT  = 13;

    localparam int PH_SEARCH  = 0;
    localparam int PH_MEASURE = 1;
    localparam int PH_LOCKED  = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        tick = 1'b0;
    logic        hs_n = 1'b1;
    logic        vs_n = 1'b1;
    logic        data_enable = 1'b0;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        pixel_valid;
    logic        frame_start;
    logic [10:0] h_total;
    logic [10:0] v_total;
    logic [10:0] h_active;
    logic [10:0] v_active;
    logic        locked;
    logic        error;

    always #5 clock = ~clock;

    lcd_timing_receiver #(
        .H_ACT(HA),
        .V_ACT(VA),
        .MAX_H(MAXH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .tick       (tick),
        .hs_n       (hs_n),
        .vs_n       (vs_n),
        .data_enable(data_enable),
        .x          (x),
        .y          (y),
        .pixel_valid(pixel_valid),
        .frame_start(frame_start),
        .h_total    (h_total),
        .v_total    (v_total),
        .h_active   (h_active),
        .v_active   (v_active),
        .locked     (locked),
        .error      (error)
    );

    int vecCount = 0;
    int errCount = 0;

    // Reference model state: tick index since reset and edge history.
    int k;
    int lastHsFall;
    int lastDeRise;
    int lastVsFall;
    int anchor;
    bit pHs, pVs, pDe, armed;
    int hsFalls[$];
    int deRises[$];
    int eX, eY, eHT, eVT, eHA, eVA;
    bit ePV, eFs, eLocked, eErr;
    int mPhase;
    int refH, refV, refHA, refVA;

    function automatic int minInt(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCount++;
        if (obs !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        k = 0;
        lastHsFall = -1;
        lastDeRise = 0;
        lastVsFall = -1;
        anchor = -1;
        pHs = 1'b1;
        pVs = 1'b1;
        pDe = 1'b0;
        armed = 1'b0;
        hsFalls.delete();
        deRises.delete();
        eX = 0; eY = 0; eHT = 0; eVT = 0; eHA = 0; eVA = 0;
        ePV = 0; eFs = 0; eLocked = 0; eErr = 0;
        mPhase = PH_SEARCH;
        refH = 0; refV = 0; refHA = 0; refVA = 0;
    endtask

    // One sampled tick of the interface, described in terms of edge history.
    task automatic modelTick(input bit hs, input bit vs, input bit de);
        bit hsF, vsF, deR, deF, stuck, lose;
        int cnt;
        hsF = pHs && !hs;
        vsF = pVs && !vs;
        deR = !pDe && de;
        deF = pDe && !de;
        eFs = 0;
        eErr = 0;
        stuck = !hsF && (k - lastHsFall == MAXH);
        if (hsF) begin
            hsFalls.push_back(k);
            eHT = minInt(k - lastHsFall, MAXH);
            lastHsFall = k;
        end
        if (deF) eHA = minInt(k - lastDeRise, MAXH);
        if (deR) begin
            deRises.push_back(k);
            lastDeRise = k;
        end
        if (vsF) begin
            cnt = 0;
            foreach (hsFalls[i]) if (hsFalls[i] > lastVsFall) cnt++;
            eVT = minInt(cnt, MAXH);
            cnt = 0;
            foreach (deRises[i]) if (deRises[i] >= lastVsFall && deRises[i] < k) cnt++;
            eVA = minInt(cnt, MAXH);
            lastVsFall = k;
            armed = 1'b1;
        end
        if (deR) begin
            if (armed) begin
                anchor = k;
                armed = 1'b0;
                eFs = 1'b1;
            end
            cnt = 0;
            foreach (deRises[i]) if (deRises[i] > anchor) cnt++;
            eY = minInt(cnt, 1023);
        end
        eX = de ? minInt(k - lastDeRise, 1023) : 0;
        ePV = de;
        case (mPhase)
            PH_SEARCH: if (vsF) mPhase = PH_MEASURE;
            PH_MEASURE: begin
                if (vsF) begin
                    if (eHT == refH && eVT == refV && eHA == refHA && eVA == refVA &&
                        eHA == HA && eVA == VA) mPhase = PH_LOCKED;
                    refH = eHT; refV = eVT; refHA = eHA; refVA = eVA;
                end
            end
            PH_LOCKED: begin
                lose = stuck || (hsF && eHT != refH) || (deF && eHA != HA) ||
                       (vsF && (eVT != refV || eVA != refVA));
                if (lose) begin
                    eErr = 1'b1;
                    mPhase = PH_MEASURE;
                    refH = eHT; refV = eVT; refHA = eHA; refVA = eVA;
                end
            end
            default: ;
        endcase
        eLocked = (mPhase == PH_LOCKED);
        pHs = hs;
        pVs = vs;
        pDe = de;
        k++;
    endtask

    // Drive one clock of inputs, advance the model, then check every output.
    task automatic applyStimulus(input bit t, input bit hs, input bit vs, input bit de, input bit rst);
        tick = t;
        hs_n = hs;
        vs_n = vs;
        data_enable = de;
        reset = rst;
        if (rst) modelReset();
        else if (t) modelTick(hs, vs, de);
        else begin
            eFs = 0;
            eErr = 0;
        end
        @(posedge clock);
        #1;
        checkOutput("x", x, eX);
        checkOutput("y", y, eY);
        checkOutput("pixel_valid", pixel_valid, ePV);
        checkOutput("frame_start", frame_start, eFs);
        checkOutput("h_total", h_total, eHT);
        checkOutput("v_total", v_total, eVT);
        checkOutput("h_active", h_active, eHA);
        checkOutput("v_active", v_active, eVA);
        checkOutput("locked", locked, eLocked);
        checkOutput("error", error, eErr);
    endtask

    // Random idle clocks with garbage inputs, then one real tick.
    task automatic sendTick(input bit hs, input bit vs, input bit de, input int minGap, input int maxGap);
        int gap;
        gap = $urandom_range(maxGap, minGap);
        repeat (gap) applyStimulus(1'b0, bit'($urandom_range(1, 0)), bit'($urandom_range(1, 0)),
                                   bit'($urandom_range(1, 0)), 1'b0);
        applyStimulus(1'b1, hs, vs, de, 1'b0);
    endtask

    task automatic runFrames(input int nFrames, input int activeW, input int shortLine,
                             input int resetAt, input int minGap, input int maxGap);
        int n;
        bit hs, vs, de;
        n = 0;
        for (int f = 0; f < nFrames; f++) begin
            for (int l = 0; l < VTOT; l++) begin
                for (int c = 0; c < HTOT; c++) begin
                    if ((f * VTOT + l == shortLine) && (c == HTOT - 1)) continue;
                    hs = (c >= HSYNC);
                    vs = (l >= VSYNC);
                    de = (l >= VSYNC + VBP) && (l < VSYNC + VBP + VA) &&
                         (c >= HSYNC + HBP) && (c < HSYNC + HBP + activeW);
                    if (n == resetAt) applyStimulus(bit'($urandom_range(1, 0)), hs, vs, de, 1'b1);
                    sendTick(hs, vs, de, minGap, maxGap);
                    n++;
                end
            end
        end
    endtask

    task automatic runStuck(input int nTicks);
        for (int i = 0; i < nTicks; i++) sendTick(1'b1, 1'b1, 1'b0, 0, 1);
    endtask

    initial begin
        modelReset();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);

        $display("[TB] nominal timing, tick every clock");
        runFrames(4, HA, -1, -1, 0, 0);
        checkOutput("lockedNominal", locked, 1);
        checkOutput("hTotalNominal", h_total, HTOT);
        checkOutput("vTotalNominal", v_total, VTOT);
        checkOutput("hActiveNominal", h_active, HA);
        checkOutput("vActiveNominal", v_active, VA);

        $display("[TB] sparse ticks");
        runFrames(2, HA, -1, -1, 0, 2);
        runFrames(2, HA, -1, -1, 2, 2);
        checkOutput("lockedSparse", locked, 1);

        $display("[TB] one short line while locked");
        runFrames(4, HA, VTOT + 5, -1, 0, 1);
        checkOutput("lockedAfterShort", locked, 1);

        $display("[TB] wrong active width");
        runFrames(4, 16, -1, -1, 0, 1);
        checkOutput("lockedNarrow", locked, 0);
        checkOutput("hActiveNarrow", h_active, 16);

        $display("[TB] reset mid-line while locked");
        runFrames(7, HA, -1, 2 * VTOT * HTOT + 3 * HTOT + 15, 0, 1);
        checkOutput("lockedAfterReset", locked, 1);

        $display("[TB] stuck inputs while locked");
        runStuck(2200);
        checkOutput("lockedStuck", locked, 0);
        checkOutput("hTotalStuck", h_total, HTOT);
        runFrames(3, HA, -1, -1, 0, 1);
        checkOutput("lockedRecovered", locked, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule

// File: doc/lcd_timing_receiver.md
Name: lcd_timing_receiver

Overview:
- Receiving end of the 800x480 LCD timing interface (hs_n, vs_n, data_enable, pixel tick).
- Recovers per-pixel x/y coordinates from a sync/DE stream and measures line and frame geometry.
- Declares lock after two consecutive identical, in-spec frames.
- Used for loopback verification of the LCD timing generator and for capturing video from external sources.

Parameters:
- H_ACT, 800, expected visible pixels per line.
- V_ACT, 480, expected visible lines per frame.
- MAX_H, 2047, saturation value of the line-length counter (11 bits).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous reset, active high.
- tick  in  1  pixel strobe, synchronous with clock; all sampling happens only on cycles with tick=1.
- hs_n  in  1  horizontal sync, active low.
- vs_n  in  1  vertical sync, active low.
- data_enable  in  1  active-pixel qualifier.
- x  out  10  recovered pixel column.
- y  out  10  recovered pixel row.
- pixel_valid  out  1  x/y refer to a visible pixel this tick.
- frame_start  out  1  one-clock pulse at the first visible pixel of a frame.
- h_total  out  11  measured ticks per line (hs_n fall to hs_n fall).
- v_total  out  11  measured lines per frame (hs_n falls between vs_n falls).
- h_active  out  11  measured data_enable-high ticks in the last complete line.
- v_active  out  11  measured lines containing data_enable in the last complete frame.
- locked  out  1  geometry stable and matches H_ACT/V_ACT.
- error  out  1  one-clock pulse on loss of lock.

Behaviour:
- Reset (clock edge with reset=1) values:
  - All outputs 0; FSM enters SEARCH.
  - Internal counters and stored measurements cleared.
  - Previous-sample registers for hs_n and vs_n set to 1; previous data_enable set to 0.
  - Reset overrides tick.
- Sampling:
  - On a tick cycle, inputs are sampled and edges are detected against the previous tick's sample.
  - Registered outputs update on that same edge, so outputs lag the input sample by 1 clock.
  - On non-tick cycles all state holds; pulses (frame_start, error) last exactly one clock.
- Pixel tracking:
  - data_enable rising edge: x=0, pixel_valid=1.
  - Each further tick with data_enable=1: x increments, saturating at 1023.
  - data_enable=0: pixel_valid=0 and x=0.
  - After a vs_n falling edge, the next data_enable rising edge sets y=0 and pulses frame_start.
  - Each subsequent data_enable rising edge increments y, saturating at 1023.
- Measurement counters:
  - hcnt counts ticks and clears on each hs_n fall; at the fall, h_total<=hcnt+1.
  - decnt counts data_enable-high ticks and latches into h_active at the data_enable falling edge.
  - Lines are counted on hs_n falls; linecnt latches into v_total at each vs_n fall.
  - Lines with data_enable are counted via data_enable rising edges; that count latches into v_active at each vs_n fall.
  - Counters saturate at MAX_H and do not wrap.
- FSM, evaluated at each vs_n falling edge:
  - SEARCH: -> MEASURE. The first partial frame is discarded.
  - MEASURE:
    - Store (h_total, v_total, h_active, v_active) as the reference.
    - If the just-completed frame equals the previous stored set, and h_active==H_ACT and v_active==V_ACT, go to LOCKED and set locked=1.
    - Otherwise stay in MEASURE.
  - LOCKED:
    - Any hs_n fall whose measured line length differs from the stored h_total, or any vs_n fall with a differing v_total/v_active, pulses error, clears locked, and returns to MEASURE, seeding the reference with the new values.
    - A data_enable fall with h_active != H_ACT has the same effect.
- Simultaneous events:
  - hs_n fall and vs_n fall on the same tick: the line is counted first, then the frame is closed, so v_total includes that line.
  - data_enable rising while hs_n is low is legal and is tracked normally.
- Inputs stuck (no hs_n fall for MAX_H ticks):
  - hcnt saturates.
  - In LOCKED: error pulses once, then MEASURE.
- Reset mid-frame: everything restarts in SEARCH; no error pulse.

Test Plan:
- Generator timing (H 24/72/96/800, V 3/10/7/480, tick every clock): locked rises at the 3rd vs_n fall; h_total=992, v_total=500, h_active=800, v_active=480.
- Same stream, locked: the first visible pixel of each frame gives frame_start=1, x=0, y=0. The last visible pixel gives x=799, y=479, pixel_valid=1. pixel_valid stays high for exactly 800 consecutive ticks per line.
- tick asserted every 3rd clock: identical measurements. x/y change only on tick clocks; frame_start width is 1 clock.
- While locked, one line shortened to 991 ticks: error pulses once at that hs_n fall and locked=0. Lock is regained after 2 clean frames.
- Active width 640 with consistent timing: measurements report h_active=640, FSM stays in MEASURE, locked never asserts.
- reset asserted for 1 clock mid-line while locked: next clock all outputs 0, no error pulse. Lock is regained at the 3rd subsequent vs_n fall.
